// File: rtl/bar_signal_monitor.sv
// bar_signal_monitor
// Front end for the bar-drawing control FSM. Raw switch levels are
// synchronised and debounced per bit. A frozen snapshot of the debounced
// levels is handed to the drawer together with a level-held redraw request.
// The snapshot only moves when a new request starts, so the drawer never
// sees a level change part-way through a frame.

module bar_signal_monitor #(
   parameter int NUM_BARS        = 3,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic [NUM_BARS-1:0] raw_signal,
   input  logic                force_redraw,
   input  logic                draw_ack,
   output logic [NUM_BARS-1:0] bar_signal,
   output logic                draw_req,
   output logic                pending
);

   // Terminal count: a differing level seen on this many consecutive edges
   // is accepted. CNT_W must be wide enough to hold DEBOUNCE_CYCLES-1.
   // Because the counter is cleared on acceptance it never wraps.
   localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } state_t;

   // Synchroniser flops
   logic [NUM_BARS-1:0] sync1_q;
   logic [NUM_BARS-1:0] sync2_q;

   // Debounce state
   logic [NUM_BARS-1:0]            stable_q;
   logic [NUM_BARS-1:0]            stable_d;
   logic [NUM_BARS-1:0][CNT_W-1:0] cnt_q;
   logic [NUM_BARS-1:0][CNT_W-1:0] cnt_d;
   logic [NUM_BARS-1:0]            accept;

   // Request handshake state
   state_t              state_q;
   state_t              state_d;
   logic                pending_q;
   logic                pending_d;
   logic [NUM_BARS-1:0] snap_q;
   logic [NUM_BARS-1:0] snap_d;
   logic                load_snap;
   logic                req_o;
   logic                pend_set;

   // Two-flop synchroniser; only sync2_q is used downstream.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= raw_signal;
         sync2_q <= sync1_q;
      end
   end

   // Per-bit debounce: count consecutive edges where the synchronised level
   // differs from the accepted one. Any return to the accepted level restarts
   // the count from zero, so no partial credit survives a bounce.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      accept   = '0;
      for (int i = 0; i < NUM_BARS; i++) begin
         if (sync2_q[i] == stable_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_TERM) begin
            stable_d[i] = sync2_q[i];
            cnt_d[i]    = '0;
            accept[i]   = 1'b1;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // Debounce registers: accepted levels and per-bit persistence counters.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         stable_q <= '0;
         cnt_q    <= '0;
      end else begin
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   // FSM state register.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: start a request whenever work is pending, and return to
   // idle only on the downstream acknowledge. An ack while idle is ignored.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (pending_q) state_d = ST_REQ;
         ST_REQ:  if (draw_ack)  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: request is high for the whole REQ state; the snapshot is
   // loaded on the same edge that leaves IDLE.
   always_comb begin
      req_o     = 1'b0;
      load_snap = 1'b0;
      case (state_q)
         ST_IDLE: load_snap = pending_q;
         ST_REQ:  req_o     = 1'b1;
         default: req_o     = 1'b0;
      endcase
   end

   // Pending flag and snapshot next-state. A new acceptance or force in the
   // same edge that consumes pending wins, so a follow-up request is issued.
   // Several bits accepted together still collapse into one pending flag.
   always_comb begin
      pend_set  = (|accept) | force_redraw;
      pending_d = pend_set | (pending_q & ~load_snap);
      snap_d    = load_snap ? stable_q : snap_q;
   end

   // Pending flag and snapshot registers. Pending comes out of reset set so
   // the first frame after reset is always drawn.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pending_q <= 1'b1;
         snap_q    <= '0;
      end else begin
         pending_q <= pending_d;
         snap_q    <= snap_d;
      end
   end

   assign bar_signal = snap_q;
   assign draw_req   = req_o;
   assign pending    = pending_q;

endmodule

// File: tb/tb_bar_signal_monitor.sv
// Self-checking bench for bar_signal_monitor with DEBOUNCE_CYCLES=4.
// A behavioural model derives the debounced levels from a sliding window of
// synchronised samples and tracks the request handshake; it is compared with
// the DUT on every falling edge. Directed literal checks pin the model.

module tb_bar_signal_monitor;

   localparam int NB = 3;
   localparam int D  = 4;
   localparam int CW = 20;

   logic          clock = 1'b0;
   logic          resetn;
   logic [NB-1:0] raw_signal;
   logic          force_redraw;
   logic          draw_ack;
   logic [NB-1:0] bar_signal;
   logic          draw_req;
   logic          pending;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   bar_signal_monitor #(
      .NUM_BARS        (NB),
      .DEBOUNCE_CYCLES (D),
      .CNT_W           (CW)
   ) dut (
      .clock        (clock),
      .resetn       (resetn),
      .raw_signal   (raw_signal),
      .force_redraw (force_redraw),
      .draw_ack     (draw_ack),
      .bar_signal   (bar_signal),
      .draw_req     (draw_req),
      .pending      (pending)
   );

   // ---------------- behavioural model ----------------
   logic [NB-1:0] m_stable;
   logic [NB-1:0] m_snap;
   bit            m_req;
   bit            m_pend;
   logic [NB-1:0] rawq[$];   // raw samples, newest first
   logic [NB-1:0] s2q[$];    // synchronised level seen at each edge, newest first

   task automatic m_reset();
      m_stable = '0;
      m_snap   = '0;
      m_req    = 1'b0;
      m_pend   = 1'b1;
      rawq.delete();
      s2q.delete();
   endtask

   task automatic m_step();
      logic [NB-1:0] s2;
      logic [NB-1:0] acc;
      bit            set;
      bit            all_diff;
      // level at the debouncer is the raw input two edges ago
      s2 = (rawq.size() >= 2) ? rawq[1] : '0;
      rawq.push_front(raw_signal);
      s2q.push_front(s2);
      while (rawq.size() > 2) void'(rawq.pop_back());
      while (s2q.size() > D) void'(s2q.pop_back());
      // a bit flips when the last D synchronised samples all disagree with it
      acc = '0;
      if (s2q.size() >= D) begin
         for (int i = 0; i < NB; i++) begin
            all_diff = 1'b1;
            for (int k = 0; k < D; k++)
               if (s2q[k][i] == m_stable[i]) all_diff = 1'b0;
            acc[i] = all_diff;
         end
      end
      set = (acc != '0) || force_redraw;
      if (!m_req && m_pend) begin
         m_snap = m_stable;
         m_req  = 1'b1;
         m_pend = set;
      end else begin
         if (m_req && draw_ack) m_req = 1'b0;
         m_pend = m_pend | set;
      end
      m_stable = m_stable ^ acc;
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clock or negedge resetn);
         if (!resetn) m_reset();
         else         m_step();
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // per-cycle compare against the model
   initial begin
      forever begin
         @(negedge clock);
         chk("cyc_draw_req", 32'(draw_req),   32'(m_req));
         chk("cyc_bar",      32'(bar_signal), 32'(m_snap));
         chk("cyc_pending",  32'(pending),    32'(m_pend));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clock);
         #2;
      end
   endtask

   initial begin
      resetn       = 1'b0;
      raw_signal   = '0;
      force_redraw = 1'b0;
      draw_ack     = 1'b0;
      step(3);
      chk("rst_req",  32'(draw_req),   0);
      chk("rst_pend", 32'(pending),    1);
      chk("rst_bar",  32'(bar_signal), 0);

      // first frame after reset is always requested
      resetn = 1'b1;
      step(1);
      chk("first_req",  32'(draw_req),   1);
      chk("first_bar",  32'(bar_signal), 0);
      chk("first_pend", 32'(pending),    0);
      draw_ack = 1'b1; step(1); draw_ack = 1'b0;
      chk("ack_req",  32'(draw_req), 0);
      chk("ack_pend", 32'(pending),  0);
      step(2);
      chk("idle_hold", 32'(draw_req), 0);

      // 3-cycle glitch on bit0 is one short of acceptance
      raw_signal = 3'b001; step(3);
      raw_signal = 3'b000; step(8);
      chk("glitch_req",  32'(draw_req),   0);
      chk("glitch_pend", 32'(pending),    0);
      chk("glitch_bar",  32'(bar_signal), 0);

      // 000 -> 101: stable at E0+5, request at E0+6
      raw_signal = 3'b101; step(6);
      chk("chg_wait_req", 32'(draw_req), 0);
      chk("chg_pend",     32'(pending),  1);
      step(1);
      chk("chg_req", 32'(draw_req),   1);
      chk("chg_bar", 32'(bar_signal), 5);
      step(3);
      chk("chg_hold_req", 32'(draw_req),   1);
      chk("chg_hold_bar", 32'(bar_signal), 5);

      // change while in REQ: snapshot frozen, re-request after ack
      raw_signal = 3'b011; step(8);
      chk("req_freeze_bar", 32'(bar_signal), 5);
      chk("req_pend",       32'(pending),    1);
      draw_ack = 1'b1; step(1); draw_ack = 1'b0;
      chk("reack_gap", 32'(draw_req), 0);
      step(1);
      chk("rereq",     32'(draw_req),   1);
      chk("rereq_bar", 32'(bar_signal), 3);
      draw_ack = 1'b1; step(1); draw_ack = 1'b0;
      chk("rereq_done_req",  32'(draw_req), 0);
      chk("rereq_done_pend", 32'(pending),  0);
      step(2);

      // force in IDLE with unchanged levels
      force_redraw = 1'b1; step(1); force_redraw = 1'b0;
      chk("force_pend", 32'(pending),  1);
      chk("force_wait", 32'(draw_req), 0);
      step(1);
      chk("force_req", 32'(draw_req),   1);
      chk("force_bar", 32'(bar_signal), 3);

      // force coinciding with ack: a second request follows
      force_redraw = 1'b1; draw_ack = 1'b1; step(1);
      force_redraw = 1'b0; draw_ack = 1'b0;
      chk("fa_req",  32'(draw_req), 0);
      chk("fa_pend", 32'(pending),  1);
      step(1);
      chk("fa_rereq", 32'(draw_req), 1);

      // asynchronous reset in the middle of REQ
      #1 resetn = 1'b0;
      #1;
      chk("arst_req",  32'(draw_req),   0);
      chk("arst_bar",  32'(bar_signal), 0);
      chk("arst_pend", 32'(pending),    1);
      step(2);
      resetn = 1'b1;
      step(1);
      chk("post_rst_req", 32'(draw_req),   1);
      chk("post_rst_bar", 32'(bar_signal), 0);
      draw_ack = 1'b1; step(1); draw_ack = 1'b0;
      step(10);
      // raw 011 re-debounced after reset triggers a second request
      chk("post_rst_2nd_req", 32'(draw_req),   1);
      chk("post_rst_2nd_bar", 32'(bar_signal), 3);
      draw_ack = 1'b1; step(1); draw_ack = 1'b0;
      step(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
